// File: rtl/split_1_gen_if.sv
// Handshake and data bundle between the split_1_gen constraint generator and its consumer.
// master drives requests and out_ready; slave (the generator) drives the tuple and status.
interface split_1_gen_if;
    logic [31:0] seed;
    logic        seed_load;
    logic        start;
    logic [7:0]  count;
    logic        abort;
    logic        out_ready;
    logic        out_valid;
    logic [15:0] var_0;
    logic [21:0] var_1;
    logic [3:0]  var_2;
    logic [27:0] var_3;
    logic [18:0] var_4;
    logic [17:0] var_5;
    logic [18:0] var_6;
    logic [13:0] var_7;
    logic [15:0] var_8;
    logic [28:0] var_9;
    logic        busy;
    logic        done;
    logic [15:0] reject_cnt;

    modport master (
        output seed, seed_load, start, count, abort, out_ready,
        input  out_valid, var_0, var_1, var_2, var_3, var_4, var_5, var_6, var_7,
               var_8, var_9, busy, done, reject_cnt
    );

    modport slave (
        input  seed, seed_load, start, count, abort, out_ready,
        output out_valid, var_0, var_1, var_2, var_3, var_4, var_5, var_6, var_7,
               var_8, var_9, busy, done, reject_cnt
    );
endinterface

// File: rtl/split_1_gen.sv
// LFSR-driven constrained tuple generator: fills a 192-bit pool, checks the constraints,
// and holds each accepted tuple on a valid/ready handshake until the requested count is delivered.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | waiting for start; seed_load accepted here only
// ST_GEN   | 6 cycles stepping the LFSR and shifting it into the pool
// ST_CHECK | evaluate constraints on the pool; accept or retry
// ST_HOLD  | out_valid high, tuple frozen until out_ready
// ST_DONE  | one-cycle done pulse, then back to idle
module split_1_gen (
    input logic          clk,
    input logic          rst_n,
    split_1_gen_if.slave bus
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GEN,
        ST_CHECK,
        ST_HOLD,
        ST_DONE
    } state_t;

    localparam logic [31:0] LFSR_TAPS   = 32'h8020_0003;
    localparam logic [13:0] VAR_7_CONST = 14'h37FD;
    localparam logic [2:0]  GEN_LAST    = 3'd5;

    state_t       state;
    logic [31:0]  lfsr;
    logic [31:0]  lfsr_next;
    logic [191:0] pool;
    logic [7:0]   remaining;
    logic [2:0]   gen_cnt;
    logic [15:0]  reject_cnt_q;
    logic         out_valid_q;
    logic         done_q;
    logic         var_7_zero;
    logic         c1_ok;
    logic         c2_ok;
    logic         c9_ok;
    logic         accept;
    logic         pool_unused;

    assign lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_TAPS : 32'h0);

    // Tuple fields are read straight from the pool; the pool only moves in ST_GEN,
    // so the tuple is inherently frozen while holding.
    assign bus.var_0 = pool[15:0];
    assign bus.var_1 = pool[37:16];
    assign bus.var_2 = pool[41:38];
    assign bus.var_3 = pool[69:42];
    assign bus.var_4 = pool[88:70];
    assign bus.var_5 = pool[106:89];
    assign bus.var_6 = pool[125:107];
    assign bus.var_7 = VAR_7_CONST;
    assign bus.var_8 = pool[141:126];
    assign bus.var_9 = pool[170:142];
    assign pool_unused = ^pool[191:171];

    assign var_7_zero = (bus.var_7 == 14'd0);
    assign c1_ok      = (bus.var_4 != 19'd0) && (bus.var_1 != 22'd0);
    assign c2_ok      = (bus.var_1 != {21'd0, var_7_zero});
    assign c9_ok      = (bus.var_7 == VAR_7_CONST);
    assign accept     = c1_ok && c2_ok && c9_ok;

    assign bus.out_valid  = out_valid_q;
    assign bus.done       = done_q;
    assign bus.reject_cnt = reject_cnt_q;
    assign bus.busy       = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            lfsr         <= 32'h1;
            pool         <= '0;
            remaining    <= '0;
            gen_cnt      <= '0;
            reject_cnt_q <= '0;
            out_valid_q  <= 1'b0;
            done_q       <= 1'b0;
        end else if (state != ST_IDLE && bus.abort) begin
            // abort wins over a same-cycle handshake; lfsr and reject_cnt are kept
            state       <= ST_IDLE;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.seed_load) begin
                        lfsr <= (bus.seed == 32'd0) ? 32'h1 : bus.seed;
                    end
                    if (bus.start) begin
                        if (bus.count != 8'd0) begin
                            state        <= ST_GEN;
                            remaining    <= bus.count;
                            reject_cnt_q <= '0;
                            gen_cnt      <= GEN_LAST;
                        end else begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_GEN: begin
                    lfsr <= lfsr_next;
                    pool <= {pool[159:0], lfsr_next};
                    if (gen_cnt == 3'd0) begin
                        state <= ST_CHECK;
                    end else begin
                        gen_cnt <= gen_cnt - 3'd1;
                    end
                end
                ST_CHECK: begin
                    if (accept) begin
                        state       <= ST_HOLD;
                        out_valid_q <= 1'b1;
                    end else begin
                        state   <= ST_GEN;
                        gen_cnt <= GEN_LAST;
                        if (reject_cnt_q != 16'hFFFF) begin
                            reject_cnt_q <= reject_cnt_q + 16'd1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        remaining   <= remaining - 8'd1;
                        if (remaining != 8'd1) begin
                            state   <= ST_GEN;
                            gen_cnt <= GEN_LAST;
                        end else begin
                            state  <= ST_DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    done_q <= 1'b0;
                end
                default: begin
                    state       <= ST_IDLE;
                    out_valid_q <= 1'b0;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_split_1_gen.sv
// Directed bench for split_1_gen: a reference LFSR model queues expected tuples,
// and an independent monitor compares every held tuple against the queue head.
module tb_split_1_gen;
    localparam logic [31:0] TAPS = 32'h8020_0003;

    logic clk;
    logic rst_n;
    split_1_gen_if bus();

    split_1_gen dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int hs_cnt = 0;
    int done_cnt = 0;
    logic [191:0] exp_q[$];
    logic [31:0] m_lfsr;
    int m_rej;

    function automatic logic [31:0] step(input logic [31:0] s);
        logic [31:0] n;
        n = s >> 1;
        if (s[0]) n = n ^ TAPS;
        return n;
    endfunction

    function automatic logic [31:0] unstep(input logic [31:0] n);
        if (n[31]) return ((n ^ TAPS) << 1) | 32'h1;
        return n << 1;
    endfunction

    function automatic logic [184:0] exp_fields(input logic [191:0] p);
        return {p[15:0], p[37:16], p[41:38], p[69:42], p[88:70], p[106:89],
                p[125:107], 14'h37FD, p[141:126], p[170:142]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_tuple(input logic [184:0] act, input logic [184:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL tuple: got 0x%0h expected 0x%0h", act, exp);
        end
    endtask

    // Generate candidates until one passes, queue it, tally model rejects.
    task automatic model_tuple();
        logic [191:0] p;
        bit ok;
        int guard;
        p = '0;
        ok = 0;
        guard = 0;
        while (!ok && guard < 50) begin
            for (int i = 0; i < 6; i++) begin
                m_lfsr = step(m_lfsr);
                p = {p[159:0], m_lfsr};
            end
            ok = (p[88:70] != 19'd0) && (p[37:16] != 22'd0);
            if (!ok) m_rej++;
            guard++;
        end
        exp_q.push_back(p);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.out_valid && n < 200);
    endtask

    // Monitor: samples mid-low-phase, after the driver has settled inputs.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst_n) begin
                if (bus.done) done_cnt++;
                if (bus.out_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_valid", 64'd0, 64'd1);
                    end else begin
                        check_tuple({bus.var_0, bus.var_1, bus.var_2, bus.var_3, bus.var_4,
                                     bus.var_5, bus.var_6, bus.var_7, bus.var_8, bus.var_9},
                                    exp_fields(exp_q[0]));
                        if (bus.out_ready && !bus.abort) begin
                            void'(exp_q.pop_front());
                            hs_cnt++;
                        end
                    end
                end
            end
        end
    end

    initial begin
        int n;
        int hs0;
        int d0;
        logic [31:0] s;

        rst_n = 1'b0;
        bus.seed = '0;
        bus.seed_load = 1'b0;
        bus.start = 1'b0;
        bus.count = '0;
        bus.abort = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_done", bus.done, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_reject", bus.reject_cnt, 0);
        check("rst_var_1", bus.var_1, 0);
        check("rst_var_7", bus.var_7, 64'h37FD);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Seed 0 maps to 1; single tuple with ready held high.
        bus.seed = 32'h0;
        bus.seed_load = 1'b1;
        @(negedge clk);
        bus.seed_load = 1'b0;
        m_lfsr = 32'h1;
        m_rej = 0;
        model_tuple();
        d0 = done_cnt;
        bus.out_ready = 1'b1;
        bus.count = 8'd1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_valid(n);
        check("latency_seed1", n, 7);
        check("var_7_const", bus.var_7, 64'h37FD);
        @(negedge clk);
        check("done_after_hs", bus.done, 1);
        check("valid_drop", bus.out_valid, 0);
        @(negedge clk);
        check("done_one_cycle", bus.done, 0);
        check("idle_after_done", bus.busy, 0);
        check("done_count_run1", done_cnt - d0, 1);

        // count = 0 goes straight to the done pulse.
        bus.count = 8'd0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("cnt0_done", bus.done, 1);
        check("cnt0_busy", bus.busy, 1);
        check("cnt0_valid", bus.out_valid, 0);
        @(negedge clk);
        check("cnt0_done_end", bus.done, 0);
        check("cnt0_busy_end", bus.busy, 0);

        // count = 4 with back-pressure; lfsr carries on from the previous run.
        m_rej = 0;
        for (int k = 0; k < 4; k++) model_tuple();
        hs0 = hs_cnt;
        d0 = done_cnt;
        bus.out_ready = 1'b0;
        bus.count = 8'd4;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_valid(n);
            check("hold_reached", bus.out_valid, 1);
            repeat (10) @(negedge clk);
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("cnt4_handshakes", hs_cnt - hs0, 4);
        check("cnt4_done", done_cnt - d0, 1);
        check("cnt4_reject", bus.reject_cnt, m_rej);
        check("cnt4_idle", bus.busy, 0);

        // Seed chosen so the first candidate has var_1 == 0.
        s = 32'h0000_1240;
        for (int i = 0; i < 6; i++) s = unstep(s);
        bus.seed = s;
        bus.seed_load = 1'b1;
        @(negedge clk);
        bus.seed_load = 1'b0;
        m_lfsr = s;
        m_rej = 0;
        model_tuple();
        bus.out_ready = 1'b1;
        bus.count = 8'd1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_valid(n);
        check("latency_retry", n, 14);
        check("reject_one", bus.reject_cnt, 1);
        repeat (3) @(negedge clk);

        // Abort in HOLD with ready high; simultaneous start must be ignored.
        bus.seed = 32'hC0FF_EE11;
        bus.seed_load = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.seed_load = 1'b0;
        m_lfsr = 32'hC0FF_EE11;
        m_rej = 0;
        model_tuple();
        hs0 = hs_cnt;
        d0 = done_cnt;
        bus.count = 8'd2;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_valid(n);
        check("abort_hold_reached", bus.out_valid, 1);
        bus.abort = 1'b1;
        bus.out_ready = 1'b1;
        bus.start = 1'b1;
        bus.count = 8'd1;
        @(negedge clk);
        bus.abort = 1'b0;
        bus.out_ready = 1'b0;
        bus.start = 1'b0;
        check("abort_idle", bus.busy, 0);
        check("abort_valid", bus.out_valid, 0);
        @(negedge clk);
        check("abort_start_ignored", bus.busy, 0);
        check("abort_no_hs", hs_cnt - hs0, 0);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_reject_kept", bus.reject_cnt, m_rej);
        exp_q.delete();

        // Async reset during GEN, then rerun with the same seed.
        bus.seed = 32'hDEAD_BEEF;
        bus.seed_load = 1'b1;
        @(negedge clk);
        bus.seed_load = 1'b0;
        bus.out_ready = 1'b1;
        bus.count = 8'd1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        d0 = done_cnt;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_var_0", bus.var_0, 0);
        check("mid_rst_var_9", bus.var_9, 0);
        check("mid_rst_var_7", bus.var_7, 64'h37FD);
        check("mid_rst_reject", bus.reject_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_idle", bus.busy, 0);
        check("post_rst_no_done", done_cnt - d0, 0);
        bus.seed_load = 1'b1;
        @(negedge clk);
        bus.seed_load = 1'b0;
        m_lfsr = 32'hDEAD_BEEF;
        m_rej = 0;
        model_tuple();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_valid(n);
        check("rerun_latency", n, 7 * (1 + m_rej));
        repeat (3) @(negedge clk);
        check("rerun_done", done_cnt - d0, 1);
        check("queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/split_1_gen.md
SPLIT_1_GEN -- requirements
Module: split_1_gen

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk (rising edge) and rst_n (0 = reset).
REQ-002 Ports, one per line (name  direction  width  meaning):
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- seed  in  32  LFSR seed
- seed_load  in  1  load seed (IDLE only)
- start  in  1  begin a run (IDLE only)
- count  in  8  solutions requested; sampled with start
- abort  in  1  synchronous run cancel
- out_ready  in  1  consumer accepts the current tuple
- out_valid  out  1  tuple valid
- var_0..var_9  out  16,22,4,28,19,18,19,14,16,29  assignment tuple
- busy  out  1  state != IDLE
- done  out  1  one-cycle run-complete pulse
- reject_cnt  out  16  rejected candidates this run, saturating

Function
REQ-003 SHALL emit only tuples satisfying all three constraints:
- C1: var_4 != 0 and var_1 != 0.
- C2: var_1 != zero-extended (var_7 == 0).
- C9: var_7 == 14'h37FD.
REQ-004 SHALL drive var_7 as the constant 14'h37FD.
REQ-005 LFSR SHALL be 32-bit Galois: next = (lfsr >> 1) XOR (lfsr[0] ? 32'h8020_0003 : 0).
REQ-006 seed_load in IDLE SHALL set lfsr = seed, or 32'h1 if seed == 0; seed_load SHALL be ignored outside IDLE.
REQ-007 Internal 192-bit pool; each GEN cycle the LFSR SHALL step and pool <= {pool[159:0], lfsr_next}.
REQ-008 Field map from pool:
- var_0 [15:0], var_1 [37:16], var_2 [41:38], var_3 [69:42], var_4 [88:70]
- var_5 [106:89], var_6 [125:107], var_8 [141:126], var_9 [170:142]
- bits [191:171] unused.
REQ-009 FSM states: IDLE, GEN, CHECK, HOLD, DONE.
REQ-010 Transitions:
- IDLE->GEN on start with count != 0; clears reject_cnt and loads the remaining counter from count.
- IDLE->DONE on start with count == 0.
- GEN: exactly 6 cycles, then CHECK.
- CHECK->HOLD if C1, C2 and C9 all hold.
- CHECK->GEN otherwise; reject_cnt increments, saturating at 16'hFFFF.
REQ-011 HOLD:
- out_valid = 1; var outputs SHALL stay stable until a cycle with out_ready = 1.
- On that handshake, remaining decrements; next state is GEN if remaining != 0, otherwise DONE.
REQ-012 DONE SHALL last one cycle with done = 1, then go to IDLE.
REQ-013 Latency: start accepted at edge E0 -> GEN on E1..E6 -> CHECK evaluated -> out_valid high after E7 at the earliest; each retry adds 7 cycles.
REQ-014 start SHALL be ignored when not in IDLE.
REQ-015 abort in any non-IDLE state SHALL go to IDLE on the next edge, drop out_valid, emit no done, and preserve lfsr and reject_cnt.
REQ-016 abort SHALL take priority over an out_ready handshake in the same cycle; that tuple does not count as delivered.
REQ-017 out_valid SHALL be registered and high only in HOLD; done SHALL be high only in DONE.
REQ-018 The LFSR SHALL step only in GEN; across runs it continues from its last value unless reloaded.

Reset
REQ-019 While rst_n = 0, regardless of clk:
- state = IDLE; lfsr = 32'h1; pool = 0; remaining = 0.
- out_valid = 0, done = 0, busy = 0, reject_cnt = 0; var outputs = 0 except var_7 = 14'h37FD.
REQ-020 Reset asserted mid-run SHALL discard the run with no done pulse; after release the block idles until start.

Verification
REQ-021 Directed scenarios:
- Reset, seed_load seed = 0, start count = 1, out_ready = 1: out_valid first high after E7; tuple matches the software LFSR model (seed 1); var_7 = 0x37FD; done pulses on the cycle after the handshake.
- start with count = 0: done pulses on the cycle after E0; out_valid is never asserted; busy is high for exactly 1 cycle.
- count = 4 with out_ready held low for 10 cycles in each HOLD: tuple stable throughout each hold; exactly 4 handshakes; then one done.
- Model-chosen seed whose first candidate has pool[37:16] == 0: reject_cnt = 1; first out_valid after E14 instead of E7.
- abort during HOLD while out_ready = 1: no handshake counted; IDLE next cycle; no done; start in the same cycle as abort is ignored.
- rst_n pulsed low during GEN: all outputs at reset values immediately (asynchronous); a later run with the same seed reproduces the model sequence.
